// File: rtl/ir_byte_queue_pkg.sv
// ir_byte_queue_pkg: shared constants and helpers for the instruction byte queue.
// No ports; imported by the interface, the rotator and the queue top.
package ir_byte_queue_pkg;

    localparam int unsigned LINE_BYTES  = 16;
    localparam int unsigned QUEUE_BYTES = 64;
    localparam int unsigned PTR_W       = 6;
    localparam int unsigned OCC_W       = 7;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned LEN_W       = 4;
    localparam int unsigned OFS_W       = 4;
    localparam int unsigned SLOT_W      = PTR_W - OFS_W;
    localparam int unsigned SLOTS       = QUEUE_BYTES / LINE_BYTES;
    localparam int unsigned LINE_W      = LINE_BYTES * 8;
    localparam int unsigned QUEUE_W     = QUEUE_BYTES * 8;

    // Round an address down to its 16-byte line base.
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFS_W], OFS_W'(0)};
    endfunction

endpackage

// File: rtl/ir_byte_queue_if.sv
// ir_byte_queue_if: fetch/decode side signals of the instruction byte queue.
//   master : drives FLUSH, FLUSH_EIP, LINE_V, LINE_DATA, CONSUME_V, CONSUME_LEN
//   slave  : drives LINE_RDY, FETCH_ADDR, IR_V, IR, EIP_OUT, OCC
interface ir_byte_queue_if;
    import ir_byte_queue_pkg::*;

    logic               FLUSH;
    logic [ADDR_W-1:0]  FLUSH_EIP;
    logic               LINE_V;
    logic [LINE_W-1:0]  LINE_DATA;
    logic               LINE_RDY;
    logic [ADDR_W-1:0]  FETCH_ADDR;
    logic               CONSUME_V;
    logic [LEN_W-1:0]   CONSUME_LEN;
    logic               IR_V;
    logic [LINE_W-1:0]  IR;
    logic [ADDR_W-1:0]  EIP_OUT;
    logic [OCC_W-1:0]   OCC;

    modport master (
        output FLUSH, FLUSH_EIP, LINE_V, LINE_DATA, CONSUME_V, CONSUME_LEN,
        input  LINE_RDY, FETCH_ADDR, IR_V, IR, EIP_OUT, OCC
    );

    modport slave (
        input  FLUSH, FLUSH_EIP, LINE_V, LINE_DATA, CONSUME_V, CONSUME_LEN,
        output LINE_RDY, FETCH_ADDR, IR_V, IR, EIP_OUT, OCC
    );

endinterface

// File: rtl/ir_byte_queue_rotate64.sv
// ir_rotate64: combinational extractor of 16 consecutive bytes from a 64-byte ring.
//   ring_i   : 64 ring bytes, byte k at ring_i[8k+7:8k]
//   rd_ptr_i : byte index of the first byte to extract
//   ir_o     : extracted bytes, ir_o[7:0] = ring byte rd_ptr_i, wrapping modulo 64
module ir_rotate64
    import ir_byte_queue_pkg::*;
(
    input  logic [QUEUE_W-1:0] ring_i,
    input  logic [PTR_W-1:0]   rd_ptr_i,
    output logic [LINE_W-1:0]  ir_o
);

    // Index arithmetic is kept at PTR_W bits so it wraps at the ring end.
    always_comb begin : rotate
        logic [PTR_W-1:0] idx;
        idx  = '0;
        ir_o = '0;
        for (int i = 0; i < LINE_BYTES; i++) begin
            idx               = rd_ptr_i + PTR_W'(i);
            ir_o[8*i +: 8]    = ring_i[{idx, 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/ir_byte_queue.sv
// ir_byte_queue: 64-byte instruction byte queue between icache lines and decode.
//   clk, reset : clock and synchronous active-high reset
//   bus.slave  : line input (LINE_V/LINE_DATA/LINE_RDY/FETCH_ADDR),
//                decode window (IR_V/IR/EIP_OUT, CONSUME_V/CONSUME_LEN),
//                redirect (FLUSH/FLUSH_EIP) and occupancy debug (OCC)
module ir_byte_queue
    import ir_byte_queue_pkg::*;
#(
    parameter logic [31:0] RESET_EIP = 32'hFFFF_FFF0
)(
    input  logic          clk,
    input  logic          reset,
    ir_byte_queue_if.slave bus
);

    logic [LINE_W-1:0]  ring_q [SLOTS];
    logic [QUEUE_W-1:0] ring_flat;

    logic [OCC_W-1:0]   occ_q,    occ_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OFS_W-1:0]   skip_q,   skip_d;
    logic [ADDR_W-1:0]  eip_q,    eip_d;
    logic [ADDR_W-1:0]  fetch_q,  fetch_d;

    logic line_rdy_c;
    logic ir_v_c;
    logic accept_c;
    logic consume_c;
    logic [LINE_W-1:0] ir_c;

    // Handshake decode from current occupancy.
    always_comb begin
        line_rdy_c = (occ_q <= OCC_W'(QUEUE_BYTES - LINE_BYTES)) && !bus.FLUSH;
        ir_v_c     = (occ_q >= OCC_W'(LINE_BYTES));
        accept_c   = bus.LINE_V && line_rdy_c;
        consume_c  = bus.CONSUME_V && ir_v_c && (bus.CONSUME_LEN != '0);
    end

    // Next-state: redirect wins; otherwise accept and consume combine.
    // A line landing after a redirect to a mid-line address only contributes
    // the bytes at or after the redirect offset (skip).
    always_comb begin
        occ_d    = occ_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        skip_d   = skip_q;
        eip_d    = eip_q;
        fetch_d  = fetch_q;
        if (bus.FLUSH) begin
            occ_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = PTR_W'(bus.FLUSH_EIP[OFS_W-1:0]);
            skip_d   = bus.FLUSH_EIP[OFS_W-1:0];
            eip_d    = bus.FLUSH_EIP;
            fetch_d  = line_align(bus.FLUSH_EIP);
        end else begin
            if (accept_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(LINE_BYTES);
                fetch_d  = fetch_q + ADDR_W'(LINE_BYTES);
                skip_d   = '0;
                occ_d    = occ_d + OCC_W'(LINE_BYTES) - OCC_W'(skip_q);
            end
            if (consume_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(bus.CONSUME_LEN);
                eip_d    = eip_q + ADDR_W'(bus.CONSUME_LEN);
                occ_d    = occ_d - OCC_W'(bus.CONSUME_LEN);
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= PTR_W'(RESET_EIP[OFS_W-1:0]);
            skip_q   <= RESET_EIP[OFS_W-1:0];
            eip_q    <= RESET_EIP;
            fetch_q  <= line_align(RESET_EIP);
        end else begin
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            skip_q   <= skip_d;
            eip_q    <= eip_d;
            fetch_q  <= fetch_d;
        end
    end

    // Ring data is never cleared; occupancy alone defines which bytes are valid.
    always_ff @(posedge clk) begin
        if (!reset && accept_c) begin
            ring_q[wr_ptr_q[PTR_W-1:OFS_W]] <= bus.LINE_DATA;
        end
    end

    assign ring_flat = {ring_q[3], ring_q[2], ring_q[1], ring_q[0]};

    ir_rotate64 u_rotate (
        .ring_i   (ring_flat),
        .rd_ptr_i (rd_ptr_q),
        .ir_o     (ir_c)
    );

    assign bus.LINE_RDY   = line_rdy_c;
    assign bus.FETCH_ADDR = fetch_q;
    assign bus.IR_V       = ir_v_c;
    assign bus.IR         = ir_c;
    assign bus.EIP_OUT    = eip_q;
    assign bus.OCC        = occ_q;

endmodule

// File: doc/ir_byte_queue.md
IR_BYTE_QUEUE -- requirements
Module: ir_byte_queue

Interface
REQ-001 Parameter: RESET_EIP, 32'hFFFF_FFF0, first instruction address after reset.
REQ-002 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: FLUSH  in  1  redirect; discard queue, restart at FLUSH_EIP.
REQ-005 Port: FLUSH_EIP  in  32  redirect target address.
REQ-006 Port: LINE_V  in  1  icache line valid this cycle.
REQ-007 Port: LINE_DATA  in  128  16 bytes at FETCH_ADDR; byte k of the line = LINE_DATA[8k+7:8k].
REQ-008 Port: LINE_RDY  out  1  queue accepts a line this cycle.
REQ-009 Port: FETCH_ADDR  out  32  16-byte-aligned address of the next line wanted.
REQ-010 Port: CONSUME_V  in  1  decode retires the instruction at the queue head.
REQ-011 Port: CONSUME_LEN  in  4  retired instruction length, 1..15 bytes.
REQ-012 Port: IR_V  out  1  IR holds 16 valid bytes.
REQ-013 Port: IR  out  128  16 bytes starting at EIP_OUT; byte at EIP_OUT = IR[7:0].
REQ-014 Port: EIP_OUT  out  32  address of the byte at IR[7:0].
REQ-015 Port: OCC  out  7  valid byte count, 0..64 (debug).

Function
REQ-016 Storage SHALL be a 64-byte ring of 4 line slots, 6-bit write and read byte pointers wrapping modulo 64, and a 7-bit occupancy register.
REQ-017 LINE_RDY SHALL be 1 iff OCC <= 48 and FLUSH = 0; line accept = LINE_V & LINE_RDY.
REQ-018 On accept, the line SHALL be written at slot wr_ptr[5:4], wr_ptr += 16, FETCH_ADDR += 16.
REQ-019 On accept, OCC SHALL increase by 16 - skip, then skip SHALL be cleared to 0.
REQ-020 IR_V SHALL be 1 iff OCC >= 16.
REQ-021 IR SHALL be the 16 ring bytes starting at rd_ptr, wrapping modulo 64, and SHALL be combinational from the ring state.
REQ-022 Consume = CONSUME_V & IR_V & CONSUME_LEN != 0; it SHALL advance rd_ptr and EIP_OUT by CONSUME_LEN and reduce OCC by CONSUME_LEN.
REQ-023 CONSUME_V when IR_V = 0, or CONSUME_LEN = 0, SHALL be a no-op.
REQ-024 Accept and consume in the same cycle SHALL both take effect, with OCC next = OCC + (16 - skip) - CONSUME_LEN.
REQ-025 FLUSH SHALL take priority over accept and consume in the same cycle and SHALL set:
- OCC = 0, wr_ptr = 0;
- rd_ptr = {2'b00, FLUSH_EIP[3:0]}, skip = FLUSH_EIP[3:0];
- EIP_OUT = FLUSH_EIP, FETCH_ADDR = {FLUSH_EIP[31:4], 4'h0}.
- Any LINE_V in the flush cycle SHALL be dropped.
REQ-026 Latency: a line accepted in cycle N SHALL be visible in IR and OCC in cycle N+1.
REQ-027 Address arithmetic SHALL wrap modulo 2^32 with no overflow flag.

Reset
REQ-028 While reset = 1, on each clock edge the block SHALL load:
- OCC = 0, wr_ptr = 0, rd_ptr = {2'b00, RESET_EIP[3:0]}, skip = RESET_EIP[3:0];
- EIP_OUT = RESET_EIP, FETCH_ADDR = {RESET_EIP[31:4], 4'h0}.
- Outputs in the following cycle: IR_V = 0, LINE_RDY = 1.
REQ-029 Reset SHALL take priority over FLUSH, accept and consume; ring data contents need not be cleared.

Structure
REQ-030 Constants LINE_BYTES = 16, QUEUE_BYTES = 64 and PTR_W = 6 SHALL live in the shared pipeline package.
REQ-031 The 64-to-16-byte rotating extractor SHALL be a separate combinational sub-module, ir_rotate64.

Verification
REQ-032 After reset with RESET_EIP = FFFF_FFF0, write line 00..0F -> IR_V = 1, IR[7:0] = 00, EIP_OUT = FFFF_FFF0, FETCH_ADDR = 0000_0000 (wrap).
REQ-033 FLUSH_EIP = 0000_1007, then one line of bytes 00..0F -> OCC = 9, IR_V = 0, IR[7:0] = 07.
- A second line then gives OCC = 25, IR_V = 1.
REQ-034 Fill 4 lines (OCC = 64) -> LINE_RDY = 0.
- Consume 15 -> OCC = 49, LINE_RDY = 0.
- Consume 1 -> OCC = 48, LINE_RDY = 1.
REQ-035 Same-cycle line accept and consume 5 at OCC = 20 -> OCC = 31, EIP_OUT += 5.
REQ-036 rd_ptr = 60 with 20 valid bytes -> IR spans the wrap, IR[31:0] = ring bytes 60..63 and IR[127:32] = bytes 0..11.
REQ-037 FLUSH, LINE_V and CONSUME_V all asserted together -> flush values only, OCC = 0, line dropped.
- Reset asserted mid-fill -> REQ-028 values on the next edge.
